ex12: RTL and testbench

- Three-input Boolean evaluator in product-of-sums form: F = (A+B+C)·(A'+B+C').
- F is 0 exactly for ABC = 000 and ABC = 101.
- The combinational output F is the primary result, used by digital-logic exercise and vending-machine decode paths.
- A registered companion section provides a sampled copy of F, its edge pulses and saturating zero/one occurrence counters for monitoring.

---
 rtl/ex12.sv | 80 ++++++++
 tb/tb_ex12.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ex12.sv
// Three-input POS evaluator F = (A+B+C)(A'+B+C') driven by a maxterm mask,
// plus a registered monitor with edge pulses and saturating zero/one counters.
module ex12 #(
  parameter logic [7:0] MAXTERMS = 8'b0010_0001,
  parameter int         CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  input  logic             en,
  input  logic             clr_cnt,
  output logic             F,
  output logic             F_q,
  output logic [2:0]       idx_q,
  output logic             f_rise,
  output logic             f_fall,
  output logic [CNT_W-1:0] zero_cnt,
  output logic [CNT_W-1:0] one_cnt
);

  logic [2:0]       idx_p0;
  logic             vld_p0;
  logic             f_p1;
  logic [2:0]       idx_p1;
  logic             rise_p1;
  logic             fall_p1;
  logic [CNT_W-1:0] zero_p1;
  logic [CNT_W-1:0] one_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Stage p0: combinational decode, a set mask bit marks a maxterm (F=0)
  assign idx_p0 = {A, B, C};
  assign vld_p0 = en;
  assign F      = ~MAXTERMS[idx_p0];

  // Stage p1: sampled copy of F/index and edge detection against the previous sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_p1    <= 1'b0;
      idx_p1  <= 3'd0;
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end else if (vld_p0) begin
      f_p1    <= F;
      idx_p1  <= idx_p0;
      rise_p1 <= F & ~f_p1;
      fall_p1 <= ~F & f_p1;
    end else begin
      rise_p1 <= 1'b0;
      fall_p1 <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment, even when sampling is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_p1 <= '0;
      one_p1  <= '0;
    end else if (clr_cnt) begin
      zero_p1 <= '0;
      one_p1  <= '0;
    end else if (vld_p0) begin
      if (F) one_p1  <= sat_inc(one_p1);
      else   zero_p1 <= sat_inc(zero_p1);
    end
  end

  assign F_q      = f_p1;
  assign idx_q    = idx_p1;
  assign f_rise   = rise_p1;
  assign f_fall   = fall_p1;
  assign zero_cnt = zero_p1;
  assign one_cnt  = one_p1;

endmodule

// File: tb/tb_ex12.sv
// Randomized self-checking bench for ex12: default, CNT_W=2 and MAXTERMS=111-only
// instances share stimulus and are compared against a behavioural model.
module tb_ex12;

  logic clk = 1'b0;
  logic rst, A, B, C, en, clr_cnt;

  logic       F0, Fq0, rise0, fall0;
  logic [2:0] idx0;
  logic [7:0] zc0, oc0;
  logic       F1, Fq1, rise1, fall1;
  logic [2:0] idx1;
  logic [1:0] zc1, oc1;
  logic       F2, Fq2, rise2, fall2;
  logic [2:0] idx2;
  logic [7:0] zc2, oc2;

  int total = 0;
  int bad   = 0;

  // model state, one slot per instance
  bit m_fq[3];
  bit [2:0] m_idx[3];
  bit m_rise[3];
  bit m_fall[3];
  int m_zero[3];
  int m_one[3];
  int cap[3] = '{255, 3, 255};

  always #5 clk = ~clk;

  ex12 dut_d (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .en(en), .clr_cnt(clr_cnt),
    .F(F0), .F_q(Fq0), .idx_q(idx0), .f_rise(rise0), .f_fall(fall0),
    .zero_cnt(zc0), .one_cnt(oc0)
  );

  ex12 #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .en(en), .clr_cnt(clr_cnt),
    .F(F1), .F_q(Fq1), .idx_q(idx1), .f_rise(rise1), .f_fall(fall1),
    .zero_cnt(zc1), .one_cnt(oc1)
  );

  ex12 #(.MAXTERMS(8'b1000_0000)) dut_m (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C), .en(en), .clr_cnt(clr_cnt),
    .F(F2), .F_q(Fq2), .idx_q(idx2), .f_rise(rise2), .f_fall(fall2),
    .zero_cnt(zc2), .one_cnt(oc2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference function straight from the Boolean forms
  function automatic bit ref_f(input int k, input bit a, input bit b, input bit c);
    if (k == 2) return !(a && b && c);
    return (a | b | c) & (!a | b | !c);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      m_fq[k] = 0; m_idx[k] = 0; m_rise[k] = 0; m_fall[k] = 0;
      m_zero[k] = 0; m_one[k] = 0;
    end
  endfunction

  function automatic void model_edge(input bit a, input bit b, input bit c,
                                     input bit e, input bit clr);
    bit f;
    for (int k = 0; k < 3; k++) begin
      f = ref_f(k, a, b, c);
      if (e) begin
        m_rise[k] = f && !m_fq[k];
        m_fall[k] = !f && m_fq[k];
        m_fq[k]   = f;
        m_idx[k]  = {a, b, c};
      end else begin
        m_rise[k] = 0;
        m_fall[k] = 0;
      end
      if (clr) begin
        m_zero[k] = 0;
        m_one[k]  = 0;
      end else if (e) begin
        if (f) m_one[k]  = (m_one[k]  < cap[k]) ? m_one[k]  + 1 : cap[k];
        else   m_zero[k] = (m_zero[k] < cap[k]) ? m_zero[k] + 1 : cap[k];
      end
    end
  endfunction

  task automatic check_all(input string ph);
    chk({ph, ".F"},      32'(F0),    32'(ref_f(0, A, B, C)));
    chk({ph, ".F_q"},    32'(Fq0),   32'(m_fq[0]));
    chk({ph, ".idx_q"},  32'(idx0),  32'(m_idx[0]));
    chk({ph, ".f_rise"}, 32'(rise0), 32'(m_rise[0]));
    chk({ph, ".f_fall"}, 32'(fall0), 32'(m_fall[0]));
    chk({ph, ".zero"},   32'(zc0),   32'(m_zero[0]));
    chk({ph, ".one"},    32'(oc0),   32'(m_one[0]));
    chk({ph, ".s_zero"}, 32'(zc1),   32'(m_zero[1]));
    chk({ph, ".s_one"},  32'(oc1),   32'(m_one[1]));
    chk({ph, ".s_rise"}, 32'(rise1), 32'(m_rise[1]));
    chk({ph, ".m_F"},    32'(F2),    32'(ref_f(2, A, B, C)));
    chk({ph, ".m_F_q"},  32'(Fq2),   32'(m_fq[2]));
    chk({ph, ".m_fall"}, 32'(fall2), 32'(m_fall[2]));
    chk({ph, ".m_one"},  32'(oc2),   32'(m_one[2]));
  endtask

  // Inputs are set by the caller at a negedge; this consumes one rising edge.
  task automatic step(input string ph);
    @(posedge clk);
    model_edge(A, B, C, en, clr_cnt);
    #1;
    check_all(ph);
    @(negedge clk);
  endtask

  task automatic set_abc(input bit [2:0] v);
    {A, B, C} = v;
  endtask

  bit [2:0] seq[4]    = '{3'b000, 3'b001, 3'b101, 3'b101};
  bit       exp_fq[4] = '{0, 1, 0, 0};
  bit       exp_ri[4] = '{0, 1, 0, 0};
  bit       exp_fa[4] = '{0, 0, 1, 0};

  initial begin
    rst = 1'b1; en = 1'b0; clr_cnt = 1'b0;
    set_abc(3'b000);
    model_reset();
    #1;
    check_all("reset");

    // combinational: short holds, no dependence on the clock
    set_abc(3'b001); #1; chk("comb001", 32'(F0), 32'd1);
    set_abc(3'b011); #1; chk("comb011", 32'(F0), 32'd1);
    set_abc(3'b000); #1; chk("comb000", 32'(F0), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_abc(3'(i)); #1;
      chk("sweep", 32'(F0), 32'((i == 0 || i == 5) ? 0 : 1));
      chk("sweep_m", 32'(F2), 32'((i == 7) ? 0 : 1));
    end
    @(negedge clk);
    rst = 1'b0;

    // directed sequence 000, 001, 101, 101
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_abc(seq[i]);
      step("seq");
      chk("seq_fq",   32'(Fq0),   32'(exp_fq[i]));
      chk("seq_rise", 32'(rise0), 32'(exp_ri[i]));
      chk("seq_fall", 32'(fall0), 32'(exp_fa[i]));
    end
    chk("seq_zero_cnt", 32'(zc0), 32'd3);
    chk("seq_one_cnt",  32'(oc0), 32'd1);

    // enable gating
    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_abc(3'(i * 3 + 1));
      step("gate");
      chk("gate_rise", 32'(rise0), 32'd0);
      chk("gate_one",  32'(oc0),   32'd1);
    end

    // saturation of the 2-bit instance, then clear
    en = 1'b1;
    set_abc(3'b011);
    for (int i = 0; i < 5; i++) step("sat");
    chk("sat_one_w2", 32'(oc1), 32'd3);
    clr_cnt = 1'b1;
    step("clr");
    chk("clr_zero", 32'(zc0), 32'd0);
    chk("clr_one",  32'(oc0), 32'd0);
    chk("clr_one_w2", 32'(oc1), 32'd0);
    clr_cnt = 1'b0;

    // long enabled run, drives the 8-bit one counter into saturation
    for (int i = 0; i < 420; i++) begin
      set_abc(3'($urandom_range(0, 7)));
      step("run");
    end
    chk("sat_one_w8", 32'(oc0), 32'd255);

    // asynchronous reset mid-cycle with counters nonzero
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("arst");
    set_abc(3'b101); #1;
    chk("arst_F", 32'(F0), 32'd0);
    set_abc(3'b110); #1;
    chk("arst_F2", 32'(F0), 32'd1);
    @(negedge clk);
    check_all("arst_hold");
    rst = 1'b0;

    // random mix of enable, clear and inputs
    for (int i = 0; i < 600; i++) begin
      set_abc(3'($urandom_range(0, 7)));
      en      = ($urandom_range(0, 3) != 0);
      clr_cnt = ($urandom_range(0, 60) == 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
